// File: rtl/arch_state_checker.sv
// Self-check sequencer: holds the core in reset, runs it for a set number of cycles, then freezes it.
// The frozen register file and data memory are then compared against a table of expected values.
//
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   cfg_we/idx/kind/addr/data : write one expected-value table entry (ignored while busy)
//   num_checks, run_cycles : run setup, sampled when start is accepted
//   start                 : one-cycle pulse, accepted in IDLE or DONE
//   core_rst_o            : active-high reset to the core (low only while running)
//   rf_raddr/rf_rdata     : debug read port of the register file (combinational data)
//   dm_raddr/dm_rdata     : debug read port of the data memory (combinational data)
//   busy, done, pass      : status flags
//   mismatch_cnt          : number of failing entries (saturating)
//   first_fail_idx/actual : index and read value of the first failing entry
module arch_state_checker #(
    parameter int XLEN        = 32,
    parameter int NUM_CHECKS  = 8,
    parameter int RF_AW       = 5,
    parameter int DM_AW       = 10,
    parameter int CNT_W       = 16,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            cfg_we,
    input  logic [$clog2(NUM_CHECKS)-1:0]   cfg_idx,
    input  logic                            cfg_kind,
    input  logic [DM_AW-1:0]                cfg_addr,
    input  logic [XLEN-1:0]                 cfg_data,
    input  logic [$clog2(NUM_CHECKS+1)-1:0] num_checks,
    input  logic [CNT_W-1:0]                run_cycles,
    input  logic                            start,
    output logic                            core_rst_o,
    output logic [RF_AW-1:0]                rf_raddr,
    input  logic [XLEN-1:0]                 rf_rdata,
    output logic [DM_AW-1:0]                dm_raddr,
    input  logic [XLEN-1:0]                 dm_rdata,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic [CNT_W-1:0]                mismatch_cnt,
    output logic [$clog2(NUM_CHECKS)-1:0]   first_fail_idx,
    output logic [XLEN-1:0]                 first_fail_actual
);

    localparam int IW = $clog2(NUM_CHECKS);
    localparam int NW = $clog2(NUM_CHECKS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t state, nxt;

    logic             tbl_kind [NUM_CHECKS];
    logic [DM_AW-1:0] tbl_addr [NUM_CHECKS];
    logic [XLEN-1:0]  tbl_data [NUM_CHECKS];

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] run_lat;
    logic [NW-1:0]    n_lat;
    logic [NW-1:0]    ptr;
    logic             cur_kind;
    logic [XLEN-1:0]  cur_data;

    logic             accept;
    logic             hold_last;
    logic             run_last;
    logic             check_last;
    logic             miss;
    logic [XLEN-1:0]  sel;
    logic [CNT_W-1:0] mm_next;

    assign busy       = (state == S_HOLD) || (state == S_RUN) || (state == S_CHECK);
    assign done       = (state == S_DONE);
    assign core_rst_o = (state != S_RUN);

    assign accept     = start && ((state == S_IDLE) || (state == S_DONE));
    assign hold_last  = (cnt == CNT_W'(HOLD_CYCLES - 1));
    assign run_last   = (cnt == run_lat - CNT_W'(1));
    assign check_last = (ptr == n_lat);

    // ptr==0 is the address-setup cycle; from ptr==k on, entry k-1 sits on
    // the read address registers and is compared against the live rdata.
    assign sel     = cur_kind ? dm_rdata : rf_rdata;
    assign miss    = (state == S_CHECK) && (ptr != '0) && (sel != cur_data);
    assign mm_next = (miss && (mismatch_cnt != '1)) ? mismatch_cnt + CNT_W'(1)
                                                    : mismatch_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:  if (start) nxt = S_HOLD;
            S_HOLD:  if (hold_last) nxt = (run_lat == '0) ? S_CHECK : S_RUN;
            S_RUN:   if (run_last) nxt = S_CHECK;
            S_CHECK: if (check_last) nxt = S_DONE;
            S_DONE:  if (start) nxt = S_HOLD;
            default: nxt = S_IDLE;
        endcase
    end

    // Table survives reset; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (cfg_we && !busy) begin
            tbl_kind[cfg_idx] <= cfg_kind;
            tbl_addr[cfg_idx] <= cfg_addr;
            tbl_data[cfg_idx] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt               <= '0;
            run_lat           <= '0;
            n_lat             <= '0;
            ptr               <= '0;
            cur_kind          <= 1'b0;
            cur_data          <= '0;
            rf_raddr          <= '0;
            dm_raddr          <= '0;
            pass              <= 1'b0;
            mismatch_cnt      <= '0;
            first_fail_idx    <= '0;
            first_fail_actual <= '0;
        end else begin
            if (accept) begin
                n_lat             <= (num_checks > NW'(NUM_CHECKS)) ? NW'(NUM_CHECKS)
                                                                   : num_checks;
                run_lat           <= run_cycles;
                cnt               <= '0;
                pass              <= 1'b0;
                mismatch_cnt      <= '0;
                first_fail_idx    <= '0;
                first_fail_actual <= '0;
            end

            if (state == S_HOLD) cnt <= hold_last ? '0 : cnt + CNT_W'(1);
            if (state == S_RUN)  cnt <= cnt + CNT_W'(1);

            if (state != S_CHECK) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + NW'(1);
                if (ptr < n_lat) begin
                    cur_kind <= tbl_kind[ptr[IW-1:0]];
                    cur_data <= tbl_data[ptr[IW-1:0]];
                    rf_raddr <= tbl_addr[ptr[IW-1:0]][RF_AW-1:0];
                    dm_raddr <= tbl_addr[ptr[IW-1:0]];
                end
                mismatch_cnt <= mm_next;
                if (miss && (mismatch_cnt == '0)) begin
                    first_fail_idx    <= IW'(ptr - NW'(1));
                    first_fail_actual <= sel;
                end
                if (check_last) pass <= (mm_next == '0);
            end
        end
    end

endmodule

// File: tb/tb_arch_state_checker.sv
// Bench for arch_state_checker with a tiny behavioural core running
// addi x1,x0,5; addi x2,x0,10; add x3,x1,x1; sw x2,0(x0).
module tb_arch_state_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic        cfg_kind;
    logic [9:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic [3:0]  num_checks;
    logic [15:0] run_cycles;
    logic        start;
    logic        core_rst_o;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic [9:0]  dm_raddr;
    logic [31:0] dm_rdata;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] mismatch_cnt;
    logic [2:0]  first_fail_idx;
    logic [31:0] first_fail_actual;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    arch_state_checker dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_we            (cfg_we),
        .cfg_idx           (cfg_idx),
        .cfg_kind          (cfg_kind),
        .cfg_addr          (cfg_addr),
        .cfg_data          (cfg_data),
        .num_checks        (num_checks),
        .run_cycles        (run_cycles),
        .start             (start),
        .core_rst_o        (core_rst_o),
        .rf_raddr          (rf_raddr),
        .rf_rdata          (rf_rdata),
        .dm_raddr          (dm_raddr),
        .dm_rdata          (dm_rdata),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .mismatch_cnt      (mismatch_cnt),
        .first_fail_idx    (first_fail_idx),
        .first_fail_actual (first_fail_actual)
    );

    // Behavioural core: reset clears only the PC.
    logic [31:0] rf [32]   = '{default: 32'd0};
    logic [31:0] dm [1024] = '{default: 32'd0};
    int          pc = 0;

    always @(posedge clk) begin
        if (core_rst_o) begin
            pc <= 0;
        end else begin
            case (pc)
                0: rf[1] <= 32'd5;
                1: rf[2] <= 32'd10;
                2: rf[3] <= rf[1] + rf[1];
                3: dm[0] <= rf[2];
                default: ;
            endcase
            pc <= pc + 1;
        end
    end

    assign rf_rdata = rf[rf_raddr];
    assign dm_rdata = dm[dm_raddr];

    task automatic cfg_write(input int idx, input bit kind, input int addr, input int data);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_idx  = 3'(idx);
        cfg_kind = kind;
        cfg_addr = 10'(addr);
        cfg_data = 32'(data);
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    task automatic kick(input int nc, input int rc);
        @(negedge clk);
        num_checks = 4'(nc);
        run_cycles = 16'(rc);
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int base, output int lat);
        lat = base;
        while (!done && lat < 300) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic test_reset;
        #3;
        checks++;
        if (core_rst_o !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got rst=%b busy=%b done=%b pass=%b, want 1 0 0 0",
                     core_rst_o, busy, done, pass);
        end
        checks++;
        if (mismatch_cnt !== 16'd0 || first_fail_idx !== 3'd0 || first_fail_actual !== 32'd0) begin
            errors++;
            $display("FAIL reset_counters: got mm=%0d ffi=%0d ffa=%0d, want 0 0 0",
                     mismatch_cnt, first_fail_idx, first_fail_actual);
        end
        checks++;
        if (rf_raddr !== 5'd0 || dm_raddr !== 10'd0) begin
            errors++;
            $display("FAIL reset_addr: got rf=%0d dm=%0d, want 0 0", rf_raddr, dm_raddr);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_pass;
        int lat;
        kick(5, 5);
        wait_done(0, lat);
        checks++;
        if (lat !== 13) begin
            errors++;
            $display("FAIL pass_latency: got %0d, want 13", lat);
        end
        checks++;
        if (pass !== 1'b1 || mismatch_cnt !== 16'd0) begin
            errors++;
            $display("FAIL pass_result: got pass=%b mm=%0d, want 1 0", pass, mismatch_cnt);
        end
    endtask

    task automatic test_mismatch;
        int lat;
        cfg_write(3, 1'b0, 3, 11);
        kick(5, 5);
        wait_done(0, lat);
        checks++;
        if (lat !== 13) begin
            errors++;
            $display("FAIL mm_latency: got %0d, want 13", lat);
        end
        checks++;
        if (pass !== 1'b0 || mismatch_cnt !== 16'd1) begin
            errors++;
            $display("FAIL mm_result: got pass=%b mm=%0d, want 0 1", pass, mismatch_cnt);
        end
        checks++;
        if (first_fail_idx !== 3'd3 || first_fail_actual !== 32'd10) begin
            errors++;
            $display("FAIL mm_first: got idx=%0d act=%0d, want 3 10",
                     first_fail_idx, first_fail_actual);
        end
    endtask

    task automatic test_zero;
        int lat;
        kick(0, 0);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(1, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("FAIL zero_latency: got %0d, want 3", lat);
        end
        checks++;
        if (pass !== 1'b1 || mismatch_cnt !== 16'd0) begin
            errors++;
            $display("FAIL zero_result: got pass=%b mm=%0d, want 1 0", pass, mismatch_cnt);
        end
    endtask

    task automatic test_async_reset;
        int lat;
        cfg_write(3, 1'b0, 3, 10);
        kick(5, 5);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (core_rst_o !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL arst_running: got rst=%b busy=%b, want 0 1", core_rst_o, busy);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (core_rst_o !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL arst_immediate: got rst=%b busy=%b done=%b, want 1 0 0",
                     core_rst_o, busy, done);
        end
        @(negedge clk) rst = 1'b1;
        kick(5, 5);
        wait_done(0, lat);
        checks++;
        if (lat !== 13 || pass !== 1'b1 || mismatch_cnt !== 16'd0) begin
            errors++;
            $display("FAIL arst_rerun: got lat=%0d pass=%b mm=%0d, want 13 1 0",
                     lat, pass, mismatch_cnt);
        end
    endtask

    task automatic test_restart;
        int lat;
        cfg_write(1, 1'b0, 1, 6);
        kick(5, 5);
        checks++;
        if (busy !== 1'b1 || pass !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL restart_busy: got busy=%b pass=%b done=%b, want 1 0 0",
                     busy, pass, done);
        end
        cfg_write(2, 1'b0, 2, 77);
        wait_done(1, lat);
        checks++;
        if (lat !== 13 || mismatch_cnt !== 16'd1) begin
            errors++;
            $display("FAIL restart_result: got lat=%0d mm=%0d, want 13 1", lat, mismatch_cnt);
        end
        checks++;
        if (first_fail_idx !== 3'd1 || first_fail_actual !== 32'd5 || pass !== 1'b0) begin
            errors++;
            $display("FAIL restart_first: got idx=%0d act=%0d pass=%b, want 1 5 0",
                     first_fail_idx, first_fail_actual, pass);
        end
    endtask

    task automatic test_first_only;
        int lat;
        cfg_write(3, 1'b0, 3, 11);
        kick(5, 5);
        wait_done(0, lat);
        checks++;
        if (mismatch_cnt !== 16'd2) begin
            errors++;
            $display("FAIL two_count: got %0d, want 2", mismatch_cnt);
        end
        checks++;
        if (first_fail_idx !== 3'd1 || first_fail_actual !== 32'd5) begin
            errors++;
            $display("FAIL two_first: got idx=%0d act=%0d, want 1 5",
                     first_fail_idx, first_fail_actual);
        end
    endtask

    task automatic test_clamp;
        int lat;
        cfg_write(1, 1'b0, 1, 5);
        cfg_write(3, 1'b0, 3, 10);
        kick(15, 5);
        wait_done(0, lat);
        checks++;
        if (lat !== 16) begin
            errors++;
            $display("FAIL clamp_latency: got %0d, want 16", lat);
        end
        checks++;
        if (pass !== 1'b1 || mismatch_cnt !== 16'd0) begin
            errors++;
            $display("FAIL clamp_result: got pass=%b mm=%0d, want 1 0", pass, mismatch_cnt);
        end
    endtask

    initial begin
        rst        = 1'b0;
        cfg_we     = 1'b0;
        cfg_idx    = '0;
        cfg_kind   = 1'b0;
        cfg_addr   = '0;
        cfg_data   = '0;
        num_checks = '0;
        run_cycles = '0;
        start      = 1'b0;

        test_reset;

        cfg_write(0, 1'b0, 0, 0);
        cfg_write(1, 1'b0, 1, 5);
        cfg_write(2, 1'b0, 2, 10);
        cfg_write(3, 1'b0, 3, 10);
        cfg_write(4, 1'b1, 0, 10);
        cfg_write(5, 1'b0, 0, 0);
        cfg_write(6, 1'b0, 0, 0);
        cfg_write(7, 1'b0, 0, 0);

        test_pass;
        test_mismatch;
        test_zero;
        test_async_reset;
        test_restart;
        test_first_only;
        test_clamp;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arch_state_checker.md
# arch_state_checker

Synthesizable, parametrised self-check sequencer for the single-cycle core. It holds the core in reset, releases it for a programmed number of cycles, then freezes it. It then walks a table of expected register-file and data-memory values and compares each against the core's architectural state. It reports a mismatch count, the first failing entry and a pass/fail verdict. This lets the same program-level checks run on FPGA or in any simulator without testbench-side hierarchical peeks.

## Interface
Parameters:
- XLEN, 32, data width of compared values
- NUM_CHECKS, 8, depth of expected-value table
- RF_AW, 5, register-file address width
- DM_AW, 10, data-memory word-address width
- CNT_W, 16, width of run-cycle counter and mismatch counter
- HOLD_CYCLES, 2, cycles core reset is held after start

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- cfg_we  in  1  write one table entry (ignored while busy)
- cfg_idx  in  $clog2(NUM_CHECKS)  table entry index
- cfg_kind  in  1  0 = register-file target, 1 = data-memory target
- cfg_addr  in  DM_AW  target address; low RF_AW bits used when cfg_kind=0
- cfg_data  in  XLEN  expected value
- num_checks  in  $clog2(NUM_CHECKS+1)  active entries 0..NUM_CHECKS, sampled at start
- run_cycles  in  CNT_W  cycles core runs, sampled at start
- start  in  1  one-cycle pulse, accepted in IDLE or DONE
- core_rst_o  out  1  active-high reset to core
- rf_raddr  out  RF_AW  debug read address to register file
- rf_rdata  in  XLEN  combinational register-file read data
- dm_raddr  out  DM_AW  debug read address to data memory
- dm_rdata  in  XLEN  combinational data-memory read data
- busy  out  1  high in HOLD, RUN, CHECK
- done  out  1  high in DONE
- pass  out  1  valid when done: mismatch_cnt == 0
- mismatch_cnt  out  CNT_W  number of failing entries
- first_fail_idx  out  $clog2(NUM_CHECKS)  index of first failing entry
- first_fail_actual  out  XLEN  value read for first failing entry

## Operation
- FSM states: IDLE, HOLD, RUN, CHECK, DONE.
- IDLE → HOLD on start. Latch num_checks and run_cycles, clear mismatch_cnt, first_fail_idx and first_fail_actual.
- HOLD: core_rst_o=1 for exactly HOLD_CYCLES cycles, then → RUN.
- RUN: core_rst_o=0 for exactly run_cycles cycles, then → CHECK. If run_cycles=0, go HOLD → CHECK directly.
- CHECK: core_rst_o=1 freezes the core. Integration requirement: core reset clears only PC; RF and DMEM contents are retained.
  - One entry per cycle, index i = 0..num_checks-1.
  - rf_raddr and dm_raddr are driven from entry i.
  - The selected rdata is compared with the expected value on the same cycle.
  - On mismatch, mismatch_cnt increments, saturating at 2^CNT_W-1.
  - On the first mismatch only, first_fail_idx=i and first_fail_actual=rdata.
- CHECK → DONE after entry num_checks-1. If num_checks=0, go straight → DONE with pass=1.
- DONE: outputs hold; core_rst_o=1. start → HOLD (restart with current table).
- num_checks > NUM_CHECKS is clamped to NUM_CHECKS.
- start while busy is ignored. cfg_we while busy is ignored. The table is retained across runs.
- cfg_we and start in the same IDLE cycle: the table write takes effect before CHECK begins.
- The table is not cleared by rst. Its contents are undefined until written.

## Timing
- Reset values:
  - state=IDLE, core_rst_o=1, busy=0, done=0, pass=0.
  - mismatch_cnt=0, first_fail_idx=0, first_fail_actual=0, rf_raddr=0, dm_raddr=0.
- Asserting rst in any state returns to IDLE asynchronously; core_rst_o=1 immediately.
- Latency from the start edge to the done=1 edge is HOLD_CYCLES + run_cycles + num_checks + 1 cycles.
- busy rises the cycle after start is sampled. done rises the cycle after the last compare.
- pass is registered and equals (mismatch_cnt==0) whenever done=1; it is 0 otherwise.
- rf_raddr and dm_raddr are registered from the table; rdata must settle within the same cycle.

## Test plan
- Program addi x1,x0,5; addi x2,x0,10; add x3,x1,x1; sw x2,0(x0). Table {rf0=0, rf1=5, rf2=10, rf3=10, dm0=10}, num_checks=5, run_cycles=5 → done after 2+5+5+1=13 cycles, pass=1, mismatch_cnt=0.
- Same program, expected rf3=11 → pass=0, mismatch_cnt=1, first_fail_idx=3, first_fail_actual=10.
- num_checks=0, run_cycles=0 → done 3 cycles after start, pass=1. start pulsed while busy → no effect on latency.
- rst pulled low during RUN → core_rst_o=1 and busy=0 immediately. A fresh start then completes normally with the identical result.
- Restart from DONE with expected rf1 changed to 6 via cfg_we → second run reports mismatch_cnt=1, first_fail_idx=1, first_fail_actual=5. The first run's counters are cleared at start.
